// File: rtl/timer_button_conditioner_if.sv
// Board-side bundle for the timer input conditioner: raw buttons/switches in,
// debounced command pulses, preset word and button levels out.
interface timer_button_conditioner_if;
  logic       btn_start;
  logic       btn_pause;
  logic       btn_restart;
  logic [5:0] sw_in;
  logic       start_con;
  logic       pause;
  logic       restart;
  logic [5:0] time_in;
  logic [2:0] btn_level;

  modport master (
    output btn_start, btn_pause, btn_restart, sw_in,
    input  start_con, pause, restart, time_in, btn_level
  );

  modport slave (
    input  btn_start, btn_pause, btn_restart, sw_in,
    output start_con, pause, restart, time_in, btn_level
  );
endinterface

// File: rtl/timer_button_conditioner.sv
// Countdown-timer front end: 2-flop sync, per-button debounce FSMs with prioritised
// one-cycle pulses, word-level switch debounce. Optional long-press restart: TIMER_LONG_PRESS_EN.
module timer_button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
  parameter int unsigned LONG_PRESS_CYCLES = 200000000
) (
  input logic                       clk,
  input logic                       reset,
  timer_button_conditioner_if.slave bus
);
  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ARM  = CNT_W'(DEBOUNCE_CYCLES - 2);

  if (DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES < 2) begin : g_param_check
    $error("DEBOUNCE_CYCLES and LONG_PRESS_CYCLES must both be at least 2");
  end

  typedef enum logic [1:0] {STABLE_LO, CHK_HI, STABLE_HI, CHK_LO} db_state_e;

  // Button index: 0 = start, 1 = pause, 2 = restart
  logic [2:0]       btn_raw;
  logic [2:0]       btn_s1;
  logic [2:0]       btn_s2;
  logic [5:0]       sw_s1;
  logic [5:0]       sw_s2;
  logic [5:0]       sw_prev;
  logic [CNT_W-1:0] sw_cnt;
  logic [5:0]       time_q;
  db_state_e        state [3];
  logic [CNT_W-1:0] cnt   [3];
  logic [2:0]       level;
  logic [2:0]       rise;
  logic             lp_fire;
  logic             restart_req;
  logic             start_q;
  logic             pause_q;
  logic             restart_q;

  assign btn_raw = {bus.btn_restart, bus.btn_pause, bus.btn_start};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      btn_s1 <= btn_raw;
      btn_s2 <= btn_s1;
      sw_s1  <= bus.sw_in;
      sw_s2  <= sw_s1;
    end
  end

  // Acceptance is decided in the same cycle the FSM leaves CHK_HI, so the prioritised
  // pulse can be registered alongside the level without an extra pipeline stage.
  always_comb begin
    rise = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      rise[i] = (state[i] == CHK_HI) && btn_s2[i] && (cnt[i] == CNT_ARM);
    end
  end

`ifdef TIMER_LONG_PRESS_EN
  localparam int unsigned   LP_W    = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [LP_W-1:0] LP_FIRE = LP_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [LP_W-1:0] LP_SAT  = LP_W'(LONG_PRESS_CYCLES);

  logic [LP_W-1:0] lp_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lp_cnt <= '0;
    end else if (state[1] != STABLE_HI) begin
      lp_cnt <= '0;
    end else if (lp_cnt != LP_SAT) begin
      lp_cnt <= lp_cnt + LP_W'(1);
    end
  end

  // Saturating one past the fire value makes the long-press pulse one-shot per hold
  assign lp_fire = (state[1] == STABLE_HI) && (lp_cnt == LP_FIRE);
`else
  assign lp_fire = 1'b0;
`endif

  assign restart_req = rise[2] | lp_fire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 3; i++) begin
        state[i] <= STABLE_LO;
        cnt[i]   <= '0;
      end
      level     <= '0;
      start_q   <= 1'b0;
      pause_q   <= 1'b0;
      restart_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        unique case (state[i])
          STABLE_LO: begin
            if (btn_s2[i]) begin
              cnt[i]   <= '0;
              state[i] <= CHK_HI;
            end
          end
          CHK_HI: begin
            if (!btn_s2[i]) begin
              cnt[i]   <= '0;
              state[i] <= STABLE_LO;
            end else if (cnt[i] == CNT_ARM) begin
              cnt[i]   <= CNT_LAST;
              state[i] <= STABLE_HI;
              level[i] <= 1'b1;
            end else if (cnt[i] != CNT_LAST) begin
              cnt[i] <= cnt[i] + CNT_W'(1);
            end
          end
          STABLE_HI: begin
            if (!btn_s2[i]) begin
              cnt[i]   <= '0;
              state[i] <= CHK_LO;
            end
          end
          CHK_LO: begin
            if (btn_s2[i]) begin
              cnt[i]   <= '0;
              state[i] <= STABLE_HI;
            end else if (cnt[i] == CNT_ARM) begin
              cnt[i]   <= CNT_LAST;
              state[i] <= STABLE_LO;
              level[i] <= 1'b0;
            end else if (cnt[i] != CNT_LAST) begin
              cnt[i] <= cnt[i] + CNT_W'(1);
            end
          end
        endcase
      end
      restart_q <= restart_req;
      pause_q   <= rise[1] & ~restart_req;
      start_q   <= rise[0] & ~rise[1] & ~restart_req;
    end
  end

  // The switch word is only loaded whole, after it has sat unchanged long enough
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_prev <= '0;
      sw_cnt  <= '0;
      time_q  <= '0;
    end else begin
      sw_prev <= sw_s2;
      if (sw_s2 != sw_prev) begin
        sw_cnt <= '0;
      end else if (sw_cnt != CNT_LAST) begin
        sw_cnt <= sw_cnt + CNT_W'(1);
      end
      if ((sw_s2 == sw_prev) && (sw_cnt >= CNT_ARM) && (sw_s2 != time_q)) begin
        time_q <= sw_s2;
      end
    end
  end

  assign bus.start_con = start_q;
  assign bus.pause     = pause_q;
  assign bus.restart   = restart_q;
  assign bus.time_in   = time_q;
  assign bus.btn_level = level;
endmodule

// File: tb/tb_timer_button_conditioner.sv
// Scoreboard bench for timer_button_conditioner: expected pulses and time_in loads
// are queued with their due cycle when stimulus is driven and popped as they appear.
module tb_timer_button_conditioner;
  localparam int unsigned DB  = 4;
  localparam int unsigned LP  = 20;
  localparam int          LAT = DB + 2;

  localparam int K_START   = 1;
  localparam int K_PAUSE   = 2;
  localparam int K_RESTART = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  timer_button_conditioner_if bus_if ();

  timer_button_conditioner #(
    .DEBOUNCE_CYCLES  (DB),
    .LONG_PRESS_CYCLES(LP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  ev_t        pulse_q[$];
  ev_t        time_q[$];
  int         cyc     = 0;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         t0;
  logic [5:0] last_time;
  logic [2:0] mon_p;
  ev_t        mon_e;
  logic       seen_pause_level;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_pulse(input int c, input int v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    pulse_q.push_back(e);
  endtask

  task automatic push_time(input int c, input int v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    time_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    mon_p = {bus_if.restart, bus_if.pause, bus_if.start_con};
    if (reset) begin
      if (mon_p != 3'b000) begin
        if (pulse_q.size() == 0) begin
          check("unexpected_pulse", mon_p, 0);
        end else begin
          mon_e = pulse_q.pop_front();
          check("pulse_kind", mon_p, mon_e.val);
          check("pulse_cycle", cyc, mon_e.cyc);
        end
      end
      if (bus_if.time_in !== last_time) begin
        if (time_q.size() == 0) begin
          check("unexpected_time_in", bus_if.time_in, last_time);
        end else begin
          mon_e = time_q.pop_front();
          check("time_in_value", bus_if.time_in, mon_e.val);
          check("time_in_cycle", cyc, mon_e.cyc);
        end
      end
    end
    last_time = bus_if.time_in;
  end

  initial begin
    bus_if.btn_start   = 1'b0;
    bus_if.btn_pause   = 1'b0;
    bus_if.btn_restart = 1'b0;
    bus_if.sw_in       = '0;
    step(3);
    check("reset_pulses", {bus_if.restart, bus_if.pause, bus_if.start_con}, 0);
    check("reset_level", bus_if.btn_level, 0);
    check("reset_time_in", bus_if.time_in, 0);
    reset = 1'b1;
    step(4);

    // Clean press and release
    t0 = cyc;
    bus_if.btn_start = 1'b1;
    push_pulse(t0 + LAT, K_START);
    step(LAT - 1);
    check("clean_level_before", bus_if.btn_level, 3'b000);
    step(1);
    check("clean_level_after", bus_if.btn_level, 3'b001);
    step(10 - LAT);
    bus_if.btn_start = 1'b0;
    step(LAT - 1);
    check("release_level_before", bus_if.btn_level, 3'b001);
    step(1);
    check("release_level_after", bus_if.btn_level, 3'b000);
    step(4);

    // Bounce shorter than the debounce window
    seen_pause_level = 1'b0;
    bus_if.btn_pause = 1'b1; step(1);
    bus_if.btn_pause = 1'b0; step(1);
    bus_if.btn_pause = 1'b1; step(1);
    bus_if.btn_pause = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      seen_pause_level = seen_pause_level | bus_if.btn_level[1];
    end
    check("bounce_level", seen_pause_level, 1'b0);

    // Simultaneous start + restart: restart wins
    t0 = cyc;
    bus_if.btn_start   = 1'b1;
    bus_if.btn_restart = 1'b1;
    push_pulse(t0 + LAT, K_RESTART);
    step(10);
    check("simul_level", bus_if.btn_level, 3'b101);
    bus_if.btn_start   = 1'b0;
    bus_if.btn_restart = 1'b0;
    step(10);
    check("simul_release_level", bus_if.btn_level, 3'b000);
    t0 = cyc;
    bus_if.btn_start = 1'b1;
    push_pulse(t0 + LAT, K_START);
    step(10);
    bus_if.btn_start = 1'b0;
    step(10);

    // Switch word debounce
    t0 = cyc;
    bus_if.sw_in = 6'b001010;
    push_time(t0 + LAT, 6'b001010);
    step(12);
    bus_if.sw_in = 6'b001011;
    step(2);
    bus_if.sw_in = 6'b001010;
    step(12);
    check("sw_glitch_hold", bus_if.time_in, 6'b001010);
    t0 = cyc;
    bus_if.sw_in = 6'b010101;
    push_time(t0 + LAT, 6'b010101);
    step(12);

    // Reset in the middle of a restart debounce
    bus_if.btn_restart = 1'b1;
    step(4);
    reset = 1'b0;
    #1;
    check("async_reset_pulses", {bus_if.restart, bus_if.pause, bus_if.start_con}, 0);
    check("async_reset_level", bus_if.btn_level, 0);
    check("async_reset_time_in", bus_if.time_in, 0);
    step(3);
    t0 = cyc;
    reset = 1'b1;
    push_pulse(t0 + LAT, K_RESTART);
    push_time(t0 + LAT, 6'b010101);
    step(LAT + 1);
    check("post_reset_level", bus_if.btn_level, 3'b100);
    step(6);
    bus_if.btn_restart = 1'b0;
    step(10);

    // Long hold of pause
    t0 = cyc;
    bus_if.btn_pause = 1'b1;
    push_pulse(t0 + LAT, K_PAUSE);
`ifdef TIMER_LONG_PRESS_EN
    push_pulse(t0 + LAT + int'(LP), K_RESTART);
`endif
    step(30);
    check("long_hold_level", bus_if.btn_level, 3'b010);
    bus_if.btn_pause = 1'b0;
    step(15);
    check("long_release_level", bus_if.btn_level, 3'b000);

    step(5);
    check("pulse_queue_drained", pulse_q.size(), 0);
    check("time_queue_drained", time_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/timer_button_conditioner.md
Name: timer_button_conditioner

Overview:
Input front end for the countdown timer. Takes the raw board push-buttons and slide switches and produces clean, debounced, single-cycle command pulses for the timer core's start_con, pause and restart inputs, plus a stable 6-bit preset value for its in bus. It sits directly upstream of the countdown timer, in the same clk domain.

Parameters:
DEBOUNCE_CYCLES, 1000000, number of consecutive stable synchronised samples needed to accept a level change (10 ms at 100 MHz); legal minimum is 2.
CNT_W, $clog2(DEBOUNCE_CYCLES+1), width of each debounce counter; derived, not overridden.
LONG_PRESS_CYCLES, 200000000, hold time for long-press restart; used only with TIMER_LONG_PRESS_EN.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
btn_start  input  1  raw start button, active-high
btn_pause  input  1  raw pause button, active-high
btn_restart  input  1  raw restart button, active-high
sw_in  input  6  raw preset switches
start_con  output  1  one-cycle start pulse
pause  output  1  one-cycle pause pulse
restart  output  1  one-cycle restart pulse
time_in  output  6  debounced preset value
btn_level  output  3  debounced levels {restart, pause, start}

Behaviour:
- Reset (reset=0, asynchronous): all sync flops, counters, debounced levels, pulses, time_in and btn_level are cleared to 0. Release is sampled on clk.
- Synchroniser: each raw input, including every sw_in bit, passes through a 2-flop synchroniser. No logic uses the raw inputs directly.
- Per-button debounce FSM, four states:
  - STABLE_LO: stays here while sync=0. When sync=1, clear the counter and go to CHK_HI.
  - CHK_HI: the counter increments each cycle while sync=1. If sync=0, go back to STABLE_LO and clear the counter. When the counter reaches DEBOUNCE_CYCLES-1 with sync=1, go to STABLE_HI, set the level to 1 and assert the rise pulse.
  - STABLE_HI: stays here while sync=1. When sync=0, clear the counter and go to CHK_LO.
  - CHK_LO: mirrors CHK_HI. On acceptance go to STABLE_LO, set the level to 0, and assert no pulse.
- Latency: edge 1 is the first clk edge at which a raw press is sampled. The pulse is registered high after edge DEBOUNCE_CYCLES+2 and lasts exactly one cycle.
- At most one pulse per accepted press, however long the button is held. Release never pulses.
- Bounce shorter than DEBOUNCE_CYCLES consecutive cycles never changes the level and never pulses.
- Simultaneous accepted rises in the same cycle are resolved by priority restart > pause > start. Only the winner's output pulses and the losers' pulses are dropped. Their levels still update, so a dropped button must be released and pressed again.
- Switch bus: debounced as one 6-bit word.
  - Any synchronised bit that differs from the previous sample clears a shared counter.
  - When the word has been unchanged for DEBOUNCE_CYCLES cycles and differs from time_in, time_in is loaded.
  - time_in is never partially updated.
- Reset mid-operation: a button held through reset release is treated as a fresh press and pulses after the normal latency. The switch word present at release appears on time_in after DEBOUNCE_CYCLES+2 edges, or stays 0 if the switches are all 0.
- Counters saturate and never wrap. All outputs are registered.

Optional Feature:
TIMER_LONG_PRESS_EN
- Defined:
  - A second counter runs while pause is in STABLE_HI.
  - When it reaches LONG_PRESS_CYCLES-1, it emits one restart pulse for that press. This pulse is subject to the same priority rule as the other pulses.
  - The counter clears when pause leaves STABLE_HI.
  - The normal pause pulse at the start of the press is still issued.
- Undefined: the long-press counter and its logic are absent, holding pause has no further effect, and LONG_PRESS_CYCLES is ignored.

Test Plan:
Bench runs with DEBOUNCE_CYCLES=4 and LONG_PRESS_CYCLES=20.
- Clean press: assert btn_start for 10 cycles -> start_con high for exactly 1 cycle after edge 6 from first sample, btn_level[0]=1; release -> no pulse, level returns to 0 after 6 edges.
- Bounce: toggle btn_pause 1,0,1,0 on consecutive cycles, then hold 0 -> pause never asserts and btn_level[1] stays 0.
- Simultaneous: raise btn_start and btn_restart on the same edge and hold for 10 cycles -> restart pulses once and start_con stays 0; release both, press start alone -> start_con pulses.
- Switches: sw_in=6'b001010 held -> time_in=6'b001010 after edge 6; glitch bit 0 for 2 cycles -> time_in unchanged; change to 6'b010101 and hold -> time_in=6'b010101 with no intermediate value.
- Reset mid-debounce: hold btn_restart, pull reset low during CHK_HI -> all outputs 0 immediately; release reset with button still held -> restart pulses once after 6 edges.
- Long press (macro defined): hold btn_pause for 30 cycles -> pause pulse at edge 6, one restart pulse 20 cycles after entering STABLE_HI, nothing further; with the macro undefined -> pause pulse only.
